// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end.
// Holds the fetch FSM state type, datapath widths and the default reset PC.
// Imported by fetch_stage and fetch_skid_reg.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int IMM_W   = 16;

    localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // IDLE only exists while in reset; KILL waits out a request whose word
    // has already been made stale by a redirect.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_KILL  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_reg.sv
// Single-entry skid buffer for a fetched {instr, pc4} pair.
// Ports: i_load captures a pair, i_unload / i_clear empty the entry
// (load wins); o_valid/o_instr/o_pc4 expose the stored pair.
module fetch_skid_reg
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_unload,
    input  logic               i_clear,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [INSTR_W-1:0] i_pc4,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [INSTR_W-1:0] o_pc4
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] r_pc4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc4   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
        end else if (i_unload || i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with PC, imem req/ack handshake and IF/ID register.
// Ports: imem_* fetch handshake; stall/flush/redirect_* from later stages;
// if_id_* registered instruction, PC+4 and valid; inst_15_0 immediate field.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect_valid,
    input  logic [INSTR_W-1:0] redirect_target,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [INSTR_W-1:0] if_id_pc4,
    output logic [IMM_W-1:0]   inst_15_0
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [INSTR_W-1:0] r_pc;
    logic [INSTR_W-1:0] w_pc_nxt;
    logic [INSTR_W-1:0] r_tgt;
    logic [INSTR_W-1:0] w_tgt_nxt;
    logic               r_ifid_valid;
    logic [INSTR_W-1:0] r_ifid_instr;
    logic [INSTR_W-1:0] r_ifid_pc4;

    logic               w_loadable;
    logic [INSTR_W-1:0] w_pc4;
    logic [INSTR_W-1:0] w_redir_tgt;
    logic               w_ifid_load;
    logic [INSTR_W-1:0] w_ifid_instr_nxt;
    logic [INSTR_W-1:0] w_ifid_pc4_nxt;
    logic               w_skid_load;
    logic               w_skid_unload;
    logic               w_skid_clear;
    logic               w_skid_vld;
    logic [INSTR_W-1:0] w_skid_instr;
    logic [INSTR_W-1:0] w_skid_pc4;

    // A flush makes IF/ID writable even while decode is stalled.
    assign w_loadable  = !stall || flush;
    assign w_pc4       = r_pc + 32'd4;
    assign w_redir_tgt = redirect_target & ~32'h3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_tgt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_tgt   <= w_tgt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_tgt_nxt        = r_tgt;
        w_ifid_load      = 1'b0;
        w_ifid_instr_nxt = imem_rdata;
        w_ifid_pc4_nxt   = w_pc4;
        w_skid_load      = 1'b0;
        w_skid_unload    = 1'b0;
        w_skid_clear     = 1'b0;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        w_pc_nxt = w_redir_tgt;
                    end else if (w_loadable) begin
                        w_ifid_load = 1'b1;
                        w_pc_nxt    = w_pc4;
                    end else begin
                        w_skid_load = 1'b1;
                        w_pc_nxt    = w_pc4;
                        w_state_nxt = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    // Request cannot be withdrawn: keep imem_addr, park target.
                    w_tgt_nxt   = w_redir_tgt;
                    w_state_nxt = ST_KILL;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    w_skid_clear = 1'b1;
                    w_pc_nxt     = w_redir_tgt;
                    w_state_nxt  = ST_FETCH;
                end else if (w_loadable && w_skid_vld) begin
                    w_skid_unload    = 1'b1;
                    w_ifid_load      = 1'b1;
                    w_ifid_instr_nxt = w_skid_instr;
                    w_ifid_pc4_nxt   = w_skid_pc4;
                    w_state_nxt      = ST_FETCH;
                end
            end
            ST_KILL: begin
                if (imem_ack) begin
                    // A redirect arriving with the ack is the newest target.
                    w_pc_nxt    = redirect_valid ? w_redir_tgt : r_tgt;
                    w_state_nxt = ST_FETCH;
                end else if (redirect_valid) begin
                    w_tgt_nxt = w_redir_tgt;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // When decode can accept but no word arrives, IF/ID becomes a bubble so
    // the previous instruction is not issued twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= '0;
            r_ifid_pc4   <= '0;
        end else if (w_ifid_load) begin
            r_ifid_valid <= 1'b1;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_ifid_pc4   <= w_ifid_pc4_nxt;
        end else if (w_loadable) begin
            r_ifid_valid <= 1'b0;
        end
    end

    fetch_skid_reg u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_clear  (w_skid_clear),
        .i_instr  (imem_rdata),
        .i_pc4    (w_pc4),
        .o_valid  (w_skid_vld),
        .o_instr  (w_skid_instr),
        .o_pc4    (w_skid_pc4)
    );

    assign imem_req    = (r_state == ST_FETCH) || (r_state == ST_KILL);
    assign imem_addr   = r_pc;
    assign if_id_valid = r_ifid_valid;
    assign if_id_instr = r_ifid_instr;
    assign if_id_pc4   = r_ifid_pc4;
    assign inst_15_0   = r_ifid_instr[IMM_W-1:0];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [15:0] inst_15_0;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_vld;
    logic [31:0] w_instr;
    logic [31:0] w_pc4;
    logic [15:0] w_imm;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4), .inst_15_0(inst_15_0)
    );

    // Second instance checks PC wrap from the top of the address space.
    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(1'b1), .imem_rdata(32'h0),
        .stall(1'b0), .flush(1'b0),
        .redirect_valid(1'b0), .redirect_target(32'h0),
        .if_id_valid(w_vld), .if_id_instr(w_instr),
        .if_id_pc4(w_pc4), .inst_15_0(w_imm)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_pc;
    logic        kill_pend;
    logic [31:0] kill_tgt;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model of the fetch stream, evaluated mid-cycle on the inputs
    // that the coming rising edge will see.
    always @(negedge clk) begin
        if (!rst) begin
            if (if_id_valid && !stall && !flush) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected_word", if_id_instr, 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_eq("sb_instr", if_id_instr, e.instr);
                    check_eq("sb_pc4", if_id_pc4, e.pc4);
                end
            end
            if (imem_req && imem_ack) begin
                check_eq("hs_addr", imem_addr, exp_pc);
                if (redirect_valid) begin
                    exp_pc = redirect_target & ~32'h3;
                end else if (kill_pend) begin
                    exp_pc = kill_tgt;
                end else begin
                    sb_q.push_back({imem_rdata, exp_pc + 32'd4});
                    exp_pc = exp_pc + 32'd4;
                end
                kill_pend = 1'b0;
            end else if (imem_req && redirect_valid) begin
                kill_pend = 1'b1;
                kill_tgt  = redirect_target & ~32'h3;
            end
        end
    end

    initial begin
        rst = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = '0;
        stall = 1'b0;
        flush = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        exp_pc = 32'h0;
        kill_pend = 1'b0;
        kill_tgt = '0;

        // Reset values
        step();
        step();
        check_eq("rst_req", {31'b0, imem_req}, 32'd0);
        check_eq("rst_valid", {31'b0, if_id_valid}, 32'd0);
        check_eq("rst_instr", if_id_instr, 32'd0);
        check_eq("rst_pc4", if_id_pc4, 32'd0);
        check_eq("rst_addr", imem_addr, 32'd0);
        check_eq("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);

        // Zero-wait memory
        imem_ack = 1'b1;
        imem_rdata = 32'h2008_0005;
        rst = 1'b0;
        step();
        check_eq("first_req", {31'b0, imem_req}, 32'd1);
        check_eq("first_addr", imem_addr, 32'h0);
        check_eq("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        step();
        check_eq("c2_valid", {31'b0, if_id_valid}, 32'd1);
        check_eq("c2_pc4", if_id_pc4, 32'd4);
        check_eq("c2_imm", {16'b0, inst_15_0}, 32'h0000_0005);
        check_eq("c2_addr", imem_addr, 32'h4);
        check_eq("wrap_addr1", w_addr, 32'h0);
        step();
        check_eq("c3_addr", imem_addr, 32'h8);
        for (int i = 0; i < 5; i++) begin
            imem_rdata = $urandom;
            step();
        end

        // Stall during an ack: word parks in the skid buffer
        imem_rdata = 32'h8C09_FF22;
        stall = 1'b1;
        step();
        imem_ack = 1'b0;
        check_eq("hold_req", {31'b0, imem_req}, 32'd0);
        check_eq("hold_state", {30'b0, u_dut.r_state}, {30'b0, ST_HOLD});
        step();
        step();
        stall = 1'b0;
        step();
        check_eq("unhold_instr", if_id_instr, 32'h8C09_FF22);
        check_eq("unhold_req", {31'b0, imem_req}, 32'd1);
        step();

        // Redirect while the request is still pending
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0040;
        step();
        redirect_valid = 1'b0;
        check_eq("kill_addr0", imem_addr, exp_pc);
        check_eq("kill_req0", {31'b0, imem_req}, 32'd1);
        step();
        check_eq("kill_addr1", imem_addr, exp_pc);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        check_eq("kill_new_addr", imem_addr, 32'h40);
        check_eq("kill_dropped", {31'b0, if_id_valid}, 32'd0);
        step();

        // Redirect + ack + flush in the same cycle
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0123;
        imem_ack = 1'b1;
        flush = 1'b1;
        step();
        redirect_valid = 1'b0;
        flush = 1'b0;
        check_eq("rf_valid", {31'b0, if_id_valid}, 32'd0);
        check_eq("rf_addr", imem_addr, 32'h120);

        // Random stall / ack traffic
        for (int i = 0; i < 30; i++) begin
            imem_rdata = $urandom;
            imem_ack = 1'($urandom_range(0, 3) != 0);
            stall = 1'($urandom_range(0, 2) == 0);
            step();
        end
        imem_ack = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_eq("drain1", sb_q.size(), 32'd0);

        // Reset mid-request with a live IF/ID word
        imem_ack = 1'b1;
        imem_rdata = 32'hCAFE_0001;
        step();
        imem_ack = 1'b0;
        stall = 1'b1;
        step();
        check_eq("pre_rst_valid", {31'b0, if_id_valid}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_req", {31'b0, imem_req}, 32'd0);
        check_eq("arst_valid", {31'b0, if_id_valid}, 32'd0);
        check_eq("arst_instr", if_id_instr, 32'd0);
        check_eq("arst_pc4", if_id_pc4, 32'd0);
        check_eq("arst_addr", imem_addr, 32'd0);
        sb_q.delete();
        kill_pend = 1'b0;
        exp_pc = 32'h0;
        stall = 1'b0;
        imem_ack = 1'b1;
        step();
        step();
        check_eq("idle_late_ack", {31'b0, imem_req}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            imem_rdata = $urandom;
            step();
        end
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_eq("drain2", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register for the MIPS datapath. Holds the PC and runs a request/acknowledge handshake with instruction memory. Captures each returned word into the IF/ID register, applying decode stall, flush and branch/jump redirect. Directly upstream of the decode stage: the immediate field it exports feeds `Sign_Extend`.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.

Ports:
- `clk`  in  1  single clock; all state is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_req`  out  1  fetch request, held until `imem_ack`.
- `imem_addr`  out  32  word address (`pc`), stable while `imem_req` is high.
- `imem_ack`  in  1  `imem_rdata` valid; may assert in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word.
- `stall`  in  1  decode cannot accept; IF/ID holds.
- `flush`  in  1  invalidate IF/ID contents.
- `redirect_valid`  in  1  taken branch/jump.
- `redirect_target`  in  32  new PC; bits [1:0] are ignored and forced to 0.
- `if_id_valid`  out  1  IF/ID holds a live instruction.
- `if_id_instr`  out  32  registered instruction.
- `if_id_pc4`  out  32  registered PC+4 of that instruction.
- `inst_15_0`  out  16  `if_id_instr[15:0]` (combinational), to `Sign_Extend`.

## Operation
- States:
  - IDLE: reset only.
  - FETCH: `imem_req` high.
  - HOLD: word captured while stalled; `imem_req` low.
  - KILL: outstanding request must complete, then be discarded.
- IDLE -> FETCH unconditionally on the first clock after reset release.
- FETCH, `imem_ack`, no redirect, IF/ID loadable (`!stall || flush`):
  - Load IF/ID with `imem_rdata` and `pc+4`; set `if_id_valid`.
  - Set `pc <= pc+4`; remain in FETCH.
- FETCH, `imem_ack`, no redirect, IF/ID not loadable:
  - Store word and `pc+4` in the skid register; set `pc <= pc+4`; go to HOLD.
- HOLD, `stall` low or `flush` high:
  - Move skid contents into IF/ID; go to FETCH.
- HOLD, `redirect_valid`:
  - Drop the skid contents; set `pc <= target`; go to FETCH.
  - Redirect has priority over the skid transfer.
- FETCH, `redirect_valid` together with `imem_ack`:
  - Drop the returned word; set `pc <= target`; remain in FETCH.
- FETCH, `redirect_valid` without `imem_ack`:
  - Latch the target; go to KILL.
  - `imem_addr` stays at the old PC; the request is never withdrawn.
- KILL, `imem_ack`:
  - Drop the word; load the latched target into `pc`; go to FETCH.
- KILL, a further `redirect_valid`:
  - Overwrite the latched target with the newest value.
- `flush` clears `if_id_valid` unless a word loads into IF/ID in the same cycle; a loaded word wins.
- With `stall` high and `flush` low, IF/ID holds its value.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values:
  - `imem_req`=0, `if_id_valid`=0, `if_id_instr`=0, `if_id_pc4`=0.
  - `pc`=`RESET_PC`, state IDLE, skid empty.
- First `imem_req` asserts in the first cycle after reset deasserts.
- Latency: `imem_ack` in cycle N -> IF/ID valid in cycle N+1.
- With zero-wait memory (ack tied high), throughput is one instruction per cycle.
- Redirect in cycle N with ack -> `imem_addr` equals the target in cycle N+1.
- Reset asserted mid-request:
  - Return to IDLE immediately.
  - Any late `imem_ack` while in IDLE is ignored.
- `imem_req`, `imem_addr` and state are registered; `inst_15_0` is the only combinational output.

## Structure
- Shared package `mips_pkg` holds:
  - The `fetch_state_t` enum.
  - `INSTR_W`=32 and `IMM_W`=16.
  - The default reset PC constant.
- One sub-module, `fetch_skid_reg`: a single-entry buffer with load/unload/clear for {instr, pc4}.

## Test plan
- Reset release, ack tied high, `imem_rdata`=32'h2008_0005 -> `imem_addr` sequence 0, 4, 8; IF/ID valid from cycle 2 with `if_id_pc4`=4, `inst_15_0`=16'h0005.
- `stall` high for 3 cycles during an ack of 32'h8C09_FF22 -> state HOLD, `imem_req`=0; after release, `if_id_instr`=32'h8C09_FF22 and no word is lost or duplicated.
- `redirect_valid` with target 32'h0000_0040 while ack is pending 2 cycles -> `imem_addr` stays at the old PC until ack, the word is dropped, then `imem_addr`=32'h40.
- Redirect and ack in the same cycle, together with `flush` -> `if_id_valid`=0 next cycle; next `imem_addr`=target.
- `RESET_PC`=32'hFFFF_FFFC -> second fetch address is 0; `rst` pulsed mid-request -> outputs return to reset values asynchronously.
